// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: control FSM states and per-latch strobe bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALTED
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic dx_en;
    logic dx_flush;
    logic xm_en;
    logic xm_flush;
    logic mw_en;
    logic mw_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTL_RUN = '{
    pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0,
    dx_en: 1'b1, dx_flush: 1'b0,
    xm_en: 1'b1, xm_flush: 1'b0,
    mw_en: 1'b1, mw_flush: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline latch enable/flush control, dmem wait state, halt,
// and saturating stall/redirect performance counters.
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             hazard_stall,
  input  logic             redirect,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_flush,
  output logic             xm_en,
  output logic             xm_flush,
  output logic             mw_en,
  output logic             mw_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  pipe_state_t state_q;
  pipe_state_t state_d;
  logic        started_q;
  logic        started_d;
  logic        halt_q;
  logic        halt_d;
  pipe_ctrl_t  ctl;
  logic        eval;
  logic        miss;
  logic        stall_inc;
  logic        redir_inc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      started_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      halt_q    <= halt_d;
    end
  end

  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    started_d = 1'b1;
    halt_d    = halt_q;
    eval      = 1'b0;
    miss      = 1'b0;
    redir_inc = 1'b0;

    unique case (state_q)
      RUN: begin
        eval = started_q;
        miss = mem_req & ~dhit;
      end
      DWAIT: begin
        // mem_req is ignored here: the access is the one already waiting
        if (dhit) begin
          eval    = 1'b1;
          state_d = RUN;
        end
      end
      HALTED: halt_d = 1'b1;
      default: state_d = RUN;
    endcase

    if (eval) begin
      priority case (1'b1)
        halt_mem: begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end
        miss: state_d = DWAIT;
        redirect: begin
          ctl          = CTL_RUN;
          ctl.fd_flush = 1'b1;
          ctl.dx_flush = 1'b1;
          redir_inc    = 1'b1;
        end
        hazard_stall: begin
          ctl          = CTL_RUN;
          ctl.pc_en    = 1'b0;
          ctl.fd_en    = 1'b0;
          ctl.dx_flush = 1'b1;
        end
        !ihit: begin
          ctl          = CTL_RUN;
          ctl.pc_en    = 1'b0;
          ctl.fd_flush = 1'b1;
        end
        default: ctl = CTL_RUN;
      endcase
    end

    stall_inc = started_q & (state_q != HALTED) & ~ctl.pc_en;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (redir_inc),
    .count (redirect_cnt)
  );

  assign pc_en    = ctl.pc_en;
  assign fd_en    = ctl.fd_en;
  assign fd_flush = ctl.fd_flush;
  assign dx_en    = ctl.dx_en;
  assign dx_flush = ctl.dx_flush;
  assign xm_en    = ctl.xm_en;
  assign xm_flush = ctl.xm_flush;
  assign mw_en    = ctl.mw_en;
  assign mw_flush = ctl.mw_flush;
  assign halt     = halt_q;

endmodule
